csel_sub32_pipe: RTL and testbench

CSEL_SUB32_PIPE -- requirements
Module: csel_sub32_pipe

---
 rtl/csel_sub_pkg.sv | 18 +
 rtl/csel_sub_seg.sv | 18 +
 rtl/csel_sub32_pipe.sv | 123 ++++++++++++
 tb/tb_csel_sub32_pipe.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/csel_sub_pkg.sv
// Shared widths and the stage-1 register record for the two-stage carry-select subtractor.
package csel_sub_pkg;

  localparam int unsigned SUB_N = 32;
  localparam int unsigned SUB_M = 16;
  localparam int unsigned SUB_H = SUB_N - SUB_M;

  // Low-segment result plus the high operand slices waiting for stage 2.
  typedef struct packed {
    logic [SUB_M-1:0] diff_lo;
    logic             sel;
    logic             gen0;
    logic             prop0;
    logic [SUB_H-1:0] a_hi;
    logic [SUB_H-1:0] b_hi;
  } s1_rec_t;

endpackage

// File: rtl/csel_sub_seg.sv
// One segment of a + ~b + cin with group generate/propagate of a + ~b.
module csel_sub_seg #(
  parameter int unsigned W = 16
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic [W-1:0] s,
  output logic         gen,
  output logic         prop
);

  // a + ~b overflows exactly when a > b; every bit propagates exactly when a == b.
  assign s    = a + ~b + W'(cin);
  assign gen  = (a > b);
  assign prop = (a == b);

endmodule

// File: rtl/csel_sub32_pipe.sv
// Two-stage pipelined subtractor d = a - b - bin with valid/ready flow control.
// Define CSEL_SUB_SAT_EN to clamp d to zero whenever a borrow-out occurs.
module csel_sub32_pipe
  import csel_sub_pkg::*;
#(
  parameter int unsigned N = SUB_N,
  parameter int unsigned M = SUB_M
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         bin,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] d,
  output logic         bout,
  output logic         gen,
  output logic         prop
);

  localparam int unsigned H = N - M;

  logic          cin_c;
  logic [M-1:0]  lo_s_c;
  logic          g0_c;
  logic          p0_c;
  s1_rec_t       s1_d_c;
  s1_rec_t       s1_q;
  logic          s1_valid;
  logic          s1_load_c;
  logic          s2_load_c;

  logic [H-1:0]  hi_s_c;
  logic          g1_c;
  logic          p1_c;
  logic [N-1:0]  diff_c;
  logic [N-1:0]  d_c;
  logic          bout_c;
  logic          gen_c;
  logic          prop_c;

  assign cin_c = ~bin;

  // Handshake: ready never depends on in_valid.
  assign s2_load_c = ~out_valid | out_ready;
  assign s1_load_c = ~s1_valid | s2_load_c;
  assign in_ready  = s1_load_c;

  csel_sub_seg #(.W(M)) u_seg_lo (
    .a    (a[M-1:0]),
    .b    (b[M-1:0]),
    .cin  (cin_c),
    .s    (lo_s_c),
    .gen  (g0_c),
    .prop (p0_c)
  );

  always_comb begin
    s1_d_c         = '0;
    s1_d_c.diff_lo = lo_s_c;
    s1_d_c.sel     = g0_c | (p0_c & cin_c);
    s1_d_c.gen0    = g0_c;
    s1_d_c.prop0   = p0_c;
    s1_d_c.a_hi    = a[N-1:M];
    s1_d_c.b_hi    = b[N-1:M];
  end

  // Stage 1 register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_q     <= '0;
    end else if (s1_load_c) begin
      s1_valid <= in_valid;
      if (in_valid) s1_q <= s1_d_c;
    end
  end

  csel_sub_seg #(.W(H)) u_seg_hi (
    .a    (s1_q.a_hi),
    .b    (s1_q.b_hi),
    .cin  (s1_q.sel),
    .s    (hi_s_c),
    .gen  (g1_c),
    .prop (p1_c)
  );

  // High carry-out through sel equals gen | prop & cin of the whole word.
  always_comb begin
    diff_c = {hi_s_c, s1_q.diff_lo};
    bout_c = ~(g1_c | (p1_c & s1_q.sel));
    gen_c  = g1_c | (p1_c & s1_q.gen0);
    prop_c = p1_c & s1_q.prop0;
`ifdef CSEL_SUB_SAT_EN
    d_c    = bout_c ? '0 : diff_c;
`else
    d_c    = diff_c;
`endif
  end

  // Stage 2 / output register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      d         <= '0;
      bout      <= 1'b0;
      gen       <= 1'b0;
      prop      <= 1'b0;
    end else if (s2_load_c) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        d    <= d_c;
        bout <= bout_c;
        gen  <= gen_c;
        prop <= prop_c;
      end
    end
  end

endmodule

// File: tb/tb_csel_sub32_pipe.sv
// Self-checking bench for csel_sub32_pipe: directed table, flow-control sequences, random stream.
module tb_csel_sub32_pipe;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] a;
  logic [31:0] b;
  logic        bin;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] d;
  logic        bout;
  logic        gen;
  logic        prop;

  int vectors     = 0;
  int miscompares = 0;
  int delivered   = 0;

  typedef struct {
    logic [31:0] d;
    logic        bout;
    logic        gen;
    logic        prop;
  } res_t;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        bin;
    res_t        exp;
  } vec_t;

  res_t q[$];
  vec_t tbl[6];

  csel_sub32_pipe dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .bin       (bin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .d         (d),
    .bout      (bout),
    .gen       (gen),
    .prop      (prop)
  );

  always #5 clk = ~clk;

  function automatic res_t model(logic [31:0] x, logic [31:0] y, logic bi);
    res_t r;
    logic [32:0] full;
    logic [32:0] g;
    full   = {1'b0, x} - {1'b0, y} - 33'(bi);
    g      = {1'b0, x} + {1'b0, ~y};
    r.bout = full[32];
    r.d    = full[31:0];
`ifdef CSEL_SUB_SAT_EN
    if (r.bout) r.d = 32'h0;
`endif
    r.gen  = g[32];
    r.prop = (x == y);
    return r;
  endfunction

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic chk_res(string nm, res_t e);
    chk({nm, ".d"}, d, e.d);
    chk({nm, ".bout"}, 32'(bout), 32'(e.bout));
    chk({nm, ".gen"}, 32'(gen), 32'(e.gen));
    chk({nm, ".prop"}, 32'(prop), 32'(e.prop));
  endtask

  // One clock with scoreboard bookkeeping; inputs are set before the call.
  task automatic cyc(output bit acc);
    bit   del;
    bit   held;
    res_t hv;
    res_t e;
    #1;
    acc  = in_valid && in_ready;
    del  = out_valid && out_ready;
    held = out_valid && !out_ready;
    hv   = '{d: d, bout: bout, gen: gen, prop: prop};
    if (del) begin
      delivered++;
      if (q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL unexpected_output: got d=%h with empty scoreboard", d);
      end else begin
        e = q.pop_front();
        chk_res("stream", e);
      end
    end
    @(posedge clk);
    #1;
    if (acc) q.push_back(model(a, b, bin));
    if (held) begin
      chk("hold.valid", 32'(out_valid), 32'd1);
      chk("hold.d", d, hv.d);
      chk("hold.flags", {29'd0, bout, gen, prop}, {29'd0, hv.bout, hv.gen, hv.prop});
    end
  endtask

  initial begin
    bit acc;
    int lat;
    int n;

    tbl[0] = '{a: 32'h00000005, b: 32'h00000003, bin: 1'b0, exp: '{d: 32'h00000002, bout: 1'b0, gen: 1'b1, prop: 1'b0}};
`ifdef CSEL_SUB_SAT_EN
    tbl[1] = '{a: 32'h00000000, b: 32'h00000001, bin: 1'b0, exp: '{d: 32'h00000000, bout: 1'b1, gen: 1'b0, prop: 1'b0}};
    tbl[4] = '{a: 32'h00000005, b: 32'h00000005, bin: 1'b1, exp: '{d: 32'h00000000, bout: 1'b1, gen: 1'b0, prop: 1'b1}};
`else
    tbl[1] = '{a: 32'h00000000, b: 32'h00000001, bin: 1'b0, exp: '{d: 32'hFFFFFFFF, bout: 1'b1, gen: 1'b0, prop: 1'b0}};
    tbl[4] = '{a: 32'h00000005, b: 32'h00000005, bin: 1'b1, exp: '{d: 32'hFFFFFFFF, bout: 1'b1, gen: 1'b0, prop: 1'b1}};
`endif
    tbl[2] = '{a: 32'h00010000, b: 32'h00000001, bin: 1'b0, exp: '{d: 32'h0000FFFF, bout: 1'b0, gen: 1'b1, prop: 1'b0}};
    tbl[3] = '{a: 32'h12345678, b: 32'h12345678, bin: 1'b0, exp: '{d: 32'h00000000, bout: 1'b0, gen: 1'b0, prop: 1'b1}};
    tbl[5] = '{a: 32'hFFFFFFFF, b: 32'h00000000, bin: 1'b1, exp: '{d: 32'hFFFFFFFE, bout: 1'b0, gen: 1'b1, prop: 1'b0}};

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; a = '0; b = '0; bin = 1'b0;
    #12;
    chk("rst.out_valid", 32'(out_valid), 32'd0);
    chk_res("rst", '{d: 32'h0, bout: 1'b0, gen: 1'b0, prop: 1'b0});
    @(posedge clk); #1 rst_n = 1'b1;
    #1 chk("rst.in_ready", 32'(in_ready), 32'd1);

    // Directed table, one transaction at a time, latency checked.
    for (int i = 0; i < 6; i++) begin
      a = tbl[i].a; b = tbl[i].b; bin = tbl[i].bin; in_valid = 1'b1; out_ready = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      lat = 1;
      while (!out_valid && lat < 10) begin
        @(posedge clk); #1;
        lat++;
      end
      chk($sformatf("tbl%0d.latency", i), 32'(lat), 32'd2);
      chk_res($sformatf("tbl%0d", i), tbl[i].exp);
      @(posedge clk); #1;
    end

    // Backpressure: three back-to-back inputs, out_ready low for two cycles.
    q.delete();
    delivered = 0;
    out_ready = 1'b0;
    in_valid  = 1'b1;
    a = 32'h00000100; b = 32'h00000001; bin = 1'b0; cyc(acc);
    chk("bp.acc0", 32'(acc), 32'd1);
    a = 32'h00000000; b = 32'h00000002; bin = 1'b1; cyc(acc);
    chk("bp.acc1", 32'(acc), 32'd1);
    a = 32'h80000000; b = 32'h7FFFFFFF; bin = 1'b0;
    #1 chk("bp.in_ready_low", 32'(in_ready), 32'd0);
    cyc(acc);
    chk("bp.stall0", 32'(acc), 32'd0);
    cyc(acc);
    chk("bp.stall1", 32'(acc), 32'd0);
    out_ready = 1'b1;
    n = 0;
    do begin
      cyc(acc);
      n++;
    end while (!acc && n < 10);
    chk("bp.acc2", 32'(acc), 32'd1);
    in_valid = 1'b0;
    for (int i = 0; i < 6; i++) cyc(acc);
    chk("bp.delivered", 32'(delivered), 32'd3);
    chk("bp.left", 32'(q.size()), 32'd0);

    // Random stream with random backpressure.
    q.delete();
    for (int i = 0; i < 400; i++) begin
      in_valid  = ($urandom_range(3) != 0);
      out_ready = ($urandom_range(3) != 0);
      a   = $urandom;
      case ($urandom_range(3))
        0:       b = a;
        1:       b = a + 32'd1;
        2:       b = {a[31:16], 16'($urandom)};
        default: b = $urandom;
      endcase
      bin = 1'($urandom_range(1));
      cyc(acc);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) cyc(acc);
    chk("rand.left", 32'(q.size()), 32'd0);

    // Reset with two transactions in flight.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    a = 32'h0000FFFF; b = 32'h00000001; bin = 1'b0; cyc(acc);
    a = 32'h00000010; b = 32'h00000020; bin = 1'b0; cyc(acc);
    in_valid = 1'b0;
    chk("mid.out_valid_before", 32'(out_valid), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("mid.out_valid", 32'(out_valid), 32'd0);
    chk("mid.d", d, 32'h0);
    q.delete();
    @(posedge clk); #1 rst_n = 1'b1;
    out_ready = 1'b1;
    #1 chk("mid.in_ready", 32'(in_ready), 32'd1);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk($sformatf("mid.no_stale%0d", i), 32'(out_valid), 32'd0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
